ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
Instruction fetch stage that sits directly upstream of the RV32E execute/decode core. It replaces direct combinational instruction-memory lookup. It issues in-order, pipelined requests to a variable-latency instruction memory and buffers returned words in a small FIFO. Each buffered word goes to the core through a valid/ready handshake together with its pc and snpc. Redirects (dnpc from taken branches and jumps) come back from the core; on a redirect the stage flushes and discards stale in-flight responses.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset
FIFO_DEPTH, 2, fetch buffer entries; also the cap on outstanding requests plus buffered entries (power of 2, at least 2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  fetch address, word aligned
imem_rsp_valid  input  1  response valid, in request order, always accepted
imem_rsp_data  input  32  instruction word
imem_rsp_err  input  1  access fault for this response
redirect_valid  input  1  core redirect this cycle
redirect_pc  input  32  redirect target (dnpc)
out_valid  output  1  instruction available
out_ready  input  1  core consumes instruction
out_pc  output  32  pc of instruction
out_snpc  output  32  out_pc+4
out_inst  output  32  instruction word
out_fault  output  1  fetch fault (misaligned target or imem_rsp_err)

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc = resp_pc = RESET_PC.
  - FIFO count, outstanding and drop_cnt = 0; state = RUN.
  - All outputs are 0.
- State: fetch_pc (next request address), resp_pc (pc of the next non-dropped response), outstanding counter, drop_cnt, FIFO of {pc, inst, fault}. Counters are $clog2(FIFO_DEPTH+1) bits wide.
- FSM states: RUN and HALT.
  - RUN → HALT on a misaligned redirect or on an accepted response with imem_rsp_err=1.
  - HALT → RUN on an aligned redirect.
  - HALT → HALT on a misaligned redirect.
- Request issue: imem_req_valid = (state==RUN) && !redirect_valid && (outstanding + count < FIFO_DEPTH). It is combinational and non-sticky, and it may be withdrawn in a redirect cycle.
  - imem_req_addr = fetch_pc.
  - On accept: fetch_pc += 4 (wraps modulo 2^32) and outstanding++.
- Response handling: outstanding--.
  - If drop_cnt>0: discard and drop_cnt--.
  - Otherwise push {resp_pc, imem_rsp_data, imem_rsp_err} and resp_pc += 4.
  - If imem_rsp_err=1: state → HALT and drop_cnt = remaining outstanding.
  - imem_rsp_valid with outstanding==0 is a protocol violation; it is ignored and flagged by an assertion.
- Credit rule: outstanding + count ≤ FIFO_DEPTH always holds, so a push never meets a full FIFO.
- Output:
  - out_valid = count>0, driven from registered FIFO head; no same-cycle bypass.
  - Payload is forced to 0 when out_valid=0. out_snpc = out_pc + 4.
  - Pop on out_valid && out_ready. Push and pop in the same cycle keeps count.
- Latency: a response accepted in cycle N gives out_valid in cycle N+1 if the FIFO was empty.
- Redirect (highest priority over push, pop and request):
  - FIFO flushed.
  - drop_cnt = outstanding − (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is discarded.
  - fetch_pc = resp_pc = redirect_pc.
  - No request is issued in the redirect cycle.
- Misaligned redirect (redirect_pc[1:0] != 0):
  - FIFO is loaded with a single entry {redirect_pc, 32'h0, fault=1}; state = HALT.
  - No requests are issued until the next redirect.
- A redirect arriving during drop (drop_cnt>0) recomputes drop_cnt from the current outstanding count.
- Reset mid-operation clears all state. The memory side is reset by the same rst, so there are no pre-reset responses.

Test Plan:
1. Release reset, imem 1-cycle latency, data = addr^32'hFFFF_FFFF, out_ready=1 → request addresses 0x80000000, 0x80000004, 0x80000008…; first out_pc=0x80000000, out_snpc=0x80000004, out_inst=0x7FFFFFFF; sustained one instruction per cycle.
2. out_ready=0 for 10 cycles → exactly 2 requests, then imem_req_valid=0 with count=2; on out_ready=1, entries 0x80000000 and 0x80000004 appear in order and requests resume at 0x80000008.
3. Latency 3, redirect_pc=0x80000100 with 2 outstanding → both stale responses are discarded; next out_pc=0x80000100 and the next request address is 0x80000100.
4. redirect_pc=0x80000102 → next cycle out_valid=1, out_pc=0x80000102, out_fault=1, out_inst=0; no imem request until redirect 0x80000200, after which fetch restarts at 0x80000200.
5. imem_rsp_err=1 on the 0x80000008 response with 1 later request outstanding → entry pc=0x80000008 with fault=1; the following response is dropped; HALT, with imem_req_valid=0.
6. Assert rst=0 asynchronously mid-cycle with out_valid=1 → out_valid and imem_req_valid drop immediately; after release the first request address is RESET_PC.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: pipelined requests to a variable-latency imem, a small
// return buffer, and a pc/snpc/inst/fault handshake toward the RV32E core.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_snpc,
    output logic [31:0] out_inst,
    output logic        out_fault
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    // Handshakes: a transfer happens on a cycle where valid && ready are both high;
    // valid may drop without a transfer (requests are withdrawn on redirect/halt),
    // and responses carry no ready: each one is consumed in the cycle it is valid.

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc_q, resp_pc_q;
    logic [CW-1:0]  outstanding_q, outstanding_d;
    logic [CW-1:0]  count_q, drop_cnt_q;
    logic [PW-1:0]  rd_ptr_q, wr_ptr_q;

    logic [31:0]    pc_mem    [FIFO_DEPTH];
    logic [31:0]    inst_mem  [FIFO_DEPTH];
    logic           fault_mem [FIFO_DEPTH];

    logic req_fire, rsp_acc, drop_rsp, push, pop, rsp_fault, misaligned, credit_ok;

    assign rsp_acc    = imem_rsp_valid && (outstanding_q != '0);
    assign drop_rsp   = rsp_acc && (drop_cnt_q != '0);
    assign push       = rsp_acc && !drop_rsp && !redirect_valid;
    assign rsp_fault  = push && imem_rsp_err;
    assign pop        = out_valid && out_ready && !redirect_valid;
    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign credit_ok  = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_C;
    assign req_fire   = imem_req_valid && imem_req_ready;

    assign outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_acc);

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = misaligned ? HALT : RUN;
        end else if (rsp_fault) begin
            state_d = HALT;
        end
    end

    // FSM: request outputs; held low while in reset so every output reads 0
    always_comb begin
        imem_req_valid = rst && (state_q == RUN) && !redirect_valid && credit_ok;
        imem_req_addr  = imem_req_valid ? fetch_pc_q : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            count_q       <= '0;
            drop_cnt_q    <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (redirect_valid) begin
                // Everything in flight is stale; a response landing now is one of them.
                fetch_pc_q <= redirect_pc;
                resp_pc_q  <= redirect_pc;
                drop_cnt_q <= outstanding_q - CW'(rsp_acc);
                rd_ptr_q   <= '0;
                wr_ptr_q   <= misaligned ? PW'(1) : '0;
                count_q    <= misaligned ? CW'(1) : '0;
            end else begin
                if (req_fire) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (drop_rsp) begin
                    drop_cnt_q <= drop_cnt_q - CW'(1);
                end else if (rsp_fault) begin
                    drop_cnt_q <= outstanding_d;
                end
                if (push) begin
                    resp_pc_q <= resp_pc_q + 32'd4;
                    wr_ptr_q  <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    // Buffer storage needs no reset: out_valid masks every unwritten slot.
    always_ff @(posedge clk) begin
        if (misaligned) begin
            pc_mem[0]    <= redirect_pc;
            inst_mem[0]  <= 32'h0;
            fault_mem[0] <= 1'b1;
        end else if (push) begin
            pc_mem[wr_ptr_q]    <= resp_pc_q;
            inst_mem[wr_ptr_q]  <= imem_rsp_data;
            fault_mem[wr_ptr_q] <= imem_rsp_err;
        end
    end

    always_comb begin
        out_valid = (count_q != '0);
        out_pc    = out_valid ? pc_mem[rd_ptr_q] : 32'h0;
        out_snpc  = out_valid ? pc_mem[rd_ptr_q] + 32'd4 : 32'h0;
        out_inst  = out_valid ? inst_mem[rd_ptr_q] : 32'h0;
        out_fault = out_valid ? fault_mem[rd_ptr_q] : 1'b0;
    end

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst)
        !(imem_rsp_valid && (outstanding_q == '0)));

    a_credit: assert property (@(posedge clk) disable iff (!rst)
        (({1'b0, outstanding_q} + {1'b0, count_q}) <= DEPTH_C));

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a latency-programmable imem model, a queue-level
// reference model checked every cycle, and literal spot checks per scenario.
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_rsp_err = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc, out_snpc, out_inst;
  logic        out_fault;

  ifu_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_snpc(out_snpc), .out_inst(out_inst), .out_fault(out_fault)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within cycle budget at %0t", name, $time);
  endtask

  // ---------------- reference model state ----------------
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; logic fault; } entry_t;
  typedef struct packed { logic [31:0] addr; logic stale; } flight_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] due; } memreq_t;

  entry_t      m_fifo[$];
  flight_t     m_flight[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  logic        m_halted = 1'b0;

  memreq_t     mem_q[$];
  int          lat = 1;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  int          cyc = 0;
  int          req_fires = 0;

  logic        snap_rst, snap_req_valid, snap_req_ready, snap_rsp_valid, snap_rsp_err;
  logic        snap_redirect, snap_out_ready, snap_exp_rv, snap_exp_ov;
  logic [31:0] snap_req_addr, snap_rsp_data, snap_redirect_pc;

  // ---------------- compare process (negedge) ----------------
  always @(negedge clk) begin
    logic        exp_rv, exp_ov, exp_fault;
    logic [31:0] exp_addr, exp_pc, exp_inst;
    exp_rv = 1'b0; exp_ov = 1'b0; exp_fault = 1'b0;
    exp_addr = 32'h0; exp_pc = 32'h0; exp_inst = 32'h0;
    if (rst) begin
      exp_rv   = !m_halted && !redirect_valid && (m_flight.size() + m_fifo.size() < DEPTH);
      exp_addr = exp_rv ? m_fetch_pc : 32'h0;
      if (m_fifo.size() > 0) begin
        exp_ov    = 1'b1;
        exp_pc    = m_fifo[0].pc;
        exp_inst  = m_fifo[0].inst;
        exp_fault = m_fifo[0].fault;
      end
    end
    check("req_valid", {31'h0, imem_req_valid}, {31'h0, exp_rv});
    check("req_addr", imem_req_addr, exp_addr);
    check("out_valid", {31'h0, out_valid}, {31'h0, exp_ov});
    check("out_pc", out_pc, exp_pc);
    check("out_snpc", out_snpc, exp_ov ? exp_pc + 32'd4 : 32'h0);
    check("out_inst", out_inst, exp_inst);
    check("out_fault", {31'h0, out_fault}, {31'h0, exp_fault});

    snap_rst = rst; snap_req_valid = imem_req_valid; snap_req_ready = imem_req_ready;
    snap_req_addr = imem_req_addr; snap_rsp_valid = imem_rsp_valid;
    snap_rsp_data = imem_rsp_data; snap_rsp_err = imem_rsp_err;
    snap_redirect = redirect_valid; snap_redirect_pc = redirect_pc;
    snap_out_ready = out_ready; snap_exp_rv = exp_rv; snap_exp_ov = exp_ov;
  end

  // ---------------- model update + imem model (posedge) ----------------
  always @(posedge clk) begin
    flight_t f;
    entry_t  e;
    memreq_t m;
    logic    issue;
    cyc++;
    if (!rst || !snap_rst) begin
      m_fifo.delete();
      m_flight.delete();
      mem_q.delete();
      m_fetch_pc = RESET_PC;
      m_halted   = 1'b0;
    end else begin
      if (snap_req_valid && snap_req_ready) begin
        m.addr = snap_req_addr;
        m.due  = 32'(cyc + lat - 1);
        mem_q.push_back(m);
        req_fires++;
      end
      if (snap_redirect) begin
        if (snap_rsp_valid && m_flight.size() > 0) m_flight.delete(0);
        foreach (m_flight[i]) m_flight[i].stale = 1'b1;
        m_fifo.delete();
        m_halted = (snap_redirect_pc[1:0] != 2'b00);
        if (m_halted) begin
          e.pc = snap_redirect_pc; e.inst = 32'h0; e.fault = 1'b1;
          m_fifo.push_back(e);
        end
        m_fetch_pc = snap_redirect_pc;
      end else begin
        issue = snap_exp_rv && snap_req_ready;
        if (snap_exp_ov && snap_out_ready) m_fifo.delete(0);
        if (snap_rsp_valid && m_flight.size() > 0) begin
          f = m_flight.pop_front();
          if (!f.stale) begin
            e.pc = f.addr; e.inst = snap_rsp_data; e.fault = snap_rsp_err;
            m_fifo.push_back(e);
            if (snap_rsp_err) begin
              m_halted = 1'b1;
              foreach (m_flight[i]) m_flight[i].stale = 1'b1;
            end
          end
        end
        if (issue) begin
          f.addr = m_fetch_pc; f.stale = m_halted;
          m_flight.push_back(f);
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
    end
    #1;
    if (rst && mem_q.size() > 0 && mem_q[0].due <= 32'(cyc)) begin
      m = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = m.addr ^ 32'hFFFF_FFFF;
      imem_rsp_err   = err_en && (m.addr == err_addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_rsp_err   = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    req_fires = 0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp_addr);
    int n;
    n = 0;
    while (!imem_req_valid && n < 40) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (!imem_req_valid) timeout(name);
    else check(name, imem_req_addr, exp_addr);
  endtask

  task automatic wait_out(input string name, input logic want_fault, input logic [31:0] pc,
                          input logic [31:0] inst);
    int n;
    n = 0;
    while (!(out_valid && (out_fault || !want_fault)) && n < 40) begin
      @(posedge clk);
      #3;
      n++;
    end
    if (!out_valid) begin
      timeout(name);
    end else begin
      check({name, "_pc"}, out_pc, pc);
      check({name, "_snpc"}, out_snpc, pc + 32'd4);
      check({name, "_inst"}, out_inst, inst);
      check({name, "_fault"}, {31'h0, out_fault}, {31'h0, want_fault});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1: latency 1, streaming, addresses count up from RESET_PC
    lat = 1; out_ready = 1'b1; imem_req_ready = 1'b1;
    do_reset();
    #2;
    check("t1_req0_valid", {31'h0, imem_req_valid}, 32'h1);
    check("t1_req0_addr", imem_req_addr, 32'h8000_0000);
    tick(); #2;
    check("t1_req1_addr", imem_req_addr, 32'h8000_0004);
    wait_out("t1_first", 1'b0, 32'h8000_0000, 32'h7FFF_FFFF);
    for (int i = 0; i < 24; i++) begin
      tick();
      imem_req_ready = 1'($urandom_range(0, 1));
      out_ready      = 1'($urandom_range(0, 1));
    end
    tick();
    imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (6) tick();

    // 2: core stalls, buffer fills, requests stop at two
    out_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    #2;
    check("t2_req_count", 32'(req_fires), 32'd2);
    check("t2_req_stopped", {31'h0, imem_req_valid}, 32'h0);
    check("t2_head_pc", out_pc, 32'h8000_0000);
    out_ready = 1'b1;
    wait_req("t2_resume_addr", 32'h8000_0008);
    check("t2_second_pc", out_pc, 32'h8000_0004);
    repeat (8) tick();

    // 3: latency 3, redirect with two requests outstanding
    lat = 3;
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    #2;
    check("t3_no_req_on_redirect", {31'h0, imem_req_valid}, 32'h0);
    tick();
    redirect_valid = 1'b0;
    #2;
    wait_req("t3_restart_addr", 32'h8000_0100);
    wait_out("t3_first", 1'b0, 32'h8000_0100, 32'h7FFF_FEFF);
    repeat (4) tick();

    // 4: misaligned redirect halts fetch until an aligned redirect
    redirect(32'h8000_0102);
    #2;
    wait_out("t4_misaligned", 1'b1, 32'h8000_0102, 32'h0);
    req_fires = 0;
    repeat (10) tick();
    check("t4_no_requests", 32'(req_fires), 32'd0);
    redirect(32'h8000_0200);
    #2;
    wait_req("t4_restart_addr", 32'h8000_0200);
    wait_out("t4_first", 1'b0, 32'h8000_0200, 32'h7FFF_FDFF);
    repeat (4) tick();

    // 5: access fault on 0x80000008 with a later request still in flight
    lat = 2; err_en = 1'b1; err_addr = 32'h8000_0008;
    do_reset();
    #2;
    wait_out("t5_fault", 1'b1, 32'h8000_0008, 32'h7FFF_FFF7);
    repeat (6) tick();
    #2;
    check("t5_halt_no_req", {31'h0, imem_req_valid}, 32'h0);
    check("t5_later_dropped", {31'h0, out_valid}, 32'h0);
    err_en = 1'b0;

    // 6: asynchronous reset in the middle of a cycle while output is valid
    out_ready = 1'b0;
    tick();
    redirect(32'h8000_0400);
    repeat (6) tick();
    #2;
    check("t6_pre_valid", {31'h0, out_valid}, 32'h1);
    rst = 1'b0;
    #1;
    check("t6_async_out_valid", {31'h0, out_valid}, 32'h0);
    check("t6_async_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("t6_async_out_pc", out_pc, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    #2;
    check("t6_post_reset_addr", imem_req_addr, RESET_PC);
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
